// File: rtl/cu_instr_encoder.sv
// Packs instruction fields into CU decoder words and streams them into instruction memory.
// Undecodable beats are dropped and flagged so memory only ever holds legal encodings.
//
// state | meaning
// IDLE  | no session; waiting for start
// LOAD  | session open; beats accepted while word_count < MAX_WORDS
// CLOSE | last write issuing; done pulses on exit
module cu_instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [1:0]        in_op,
   input  logic              in_imm,
   input  logic [4:0]        in_cmd,
   input  logic [3:0]        in_rd,
   input  logic [3:0]        in_rn,
   input  logic [15:0]       in_src,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err_illegal,
   output logic [ADDR_W:0]   word_count
);

   localparam logic [ADDR_W:0] MAX_CNT  = MAX_WORDS[ADDR_W:0];
   localparam logic [ADDR_W:0] MAX_LAST = MAX_CNT - 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CLOSE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic              legal;
   logic              accept;
   logic              write_en;
   logic              close_now;
   logic [31:0]       enc_word;

   always_comb begin
      legal = 1'b0;
      case (in_op)
         2'b00:   legal = (in_cmd <= 5'b01100);
         2'b01:   legal = (in_cmd[4:2] == 3'b000);
         2'b10:   legal = (in_cmd[4:1] == 4'b0000);
         default: legal = 1'b0;
      endcase
   end

   // Register-form beats only carry rm in the low nibble of src.
   assign enc_word = {in_op, in_imm, in_cmd, in_rd, in_rn,
                      in_imm ? in_src : {12'h000, in_src[3:0]}};

   assign in_ready  = (state == LOAD) && (word_count < MAX_CNT);
   assign accept    = in_valid && in_ready;
   assign write_en  = accept && legal;
   assign close_now = accept && (in_last || (legal && (word_count == MAX_LAST)));
   assign busy      = (state == LOAD);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    if (close_now) state_nxt = CLOSE;
         CLOSE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         word_count  <= '0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         done        <= 1'b0;
         err_illegal <= 1'b0;
      end else begin
         state       <= state_nxt;
         imem_we     <= write_en;
         err_illegal <= accept && !legal;
         // The final write is on the bus during CLOSE, so done follows it by one cycle.
         done        <= (state == CLOSE);
         if ((state == IDLE) && start) begin
            ptr        <= base_addr;
            word_count <= '0;
         end else if (write_en) begin
            imem_addr  <= ptr;
            imem_wdata <= enc_word;
            ptr        <= ptr + 1'b1;
            word_count <= word_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cu_instr_encoder.sv
// Scoreboard bench for cu_instr_encoder: driver pushes expected writes/errors/done pulses,
// a negedge monitor pops and compares them against what the encoder presents.
module tb_cu_instr_encoder;

   localparam int AW = 8;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic          in_valid;
   logic          in_ready;
   logic          in_last;
   logic [1:0]    in_op;
   logic          in_imm;
   logic [4:0]    in_cmd;
   logic [3:0]    in_rd;
   logic [3:0]    in_rn;
   logic [15:0]   in_src;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          busy;
   logic          done;
   logic          err_illegal;
   logic [AW:0]   word_count;

   cu_instr_encoder #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_op(in_op), .in_imm(in_imm), .in_cmd(in_cmd), .in_rd(in_rd),
      .in_rn(in_rn), .in_src(in_src), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .busy(busy), .done(done),
      .err_illegal(err_illegal), .word_count(word_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          cyc;
      int          addr;
      logic [31:0] data;
   } wr_t;

   wr_t wq[$];
   int  eq[$];
   int  dq[$];
   wr_t e_mon;
   int  c_mon;

   // Reference model: session as plain integers
   int m_ptr;
   int m_cnt;
   bit m_ready;
   bit m_busy;
   bit m_close;

   function automatic bit ref_legal(input int op, input int cmd);
      if (op == 3) return 1'b0;
      if (op == 0) return cmd <= 12;
      if (op == 1) return cmd < 4;
      return cmd < 2;
   endfunction

   function automatic logic [31:0] ref_enc(input int op, input int imm, input int cmd,
                                           input int rd, input int rn, input int src);
      longint w;
      int s;
      s = imm ? src : (src % 16);
      w = longint'(op) * 64'd1073741824 + longint'(imm) * 64'd536870912 +
          longint'(cmd) * 64'd16777216 + longint'(rd) * 64'd1048576 +
          longint'(rn) * 64'd65536 + longint'(s);
      return w[31:0];
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (!rst) begin
         while (wq.size() > 0 && wq[0].cyc < cyc) begin
            e_mon = wq.pop_front();
            chk("missed_write", 64'(0), 64'(1));
         end
         while (eq.size() > 0 && eq[0] < cyc) begin
            c_mon = eq.pop_front();
            chk("missed_err_illegal", 64'(0), 64'(1));
         end
         while (dq.size() > 0 && dq[0] < cyc) begin
            c_mon = dq.pop_front();
            chk("missed_done", 64'(0), 64'(1));
         end
         if (imem_we) begin
            if (wq.size() == 0) chk("unexpected_write", 64'(1), 64'(0));
            else begin
               e_mon = wq.pop_front();
               chk("wr_cycle", 64'(cyc), 64'(e_mon.cyc));
               chk("wr_addr", 64'(imem_addr), 64'(e_mon.addr));
               chk("wr_data", 64'(imem_wdata), 64'(e_mon.data));
            end
         end
         if (err_illegal) begin
            if (eq.size() == 0) chk("unexpected_err_illegal", 64'(1), 64'(0));
            else begin
               c_mon = eq.pop_front();
               chk("err_cycle", 64'(cyc), 64'(c_mon));
            end
         end
         if (done) begin
            if (dq.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
            else begin
               c_mon = dq.pop_front();
               chk("done_cycle", 64'(cyc), 64'(c_mon));
            end
         end
      end
   end

   // One cycle of stimulus; called just after a negedge, returns at the next negedge.
   task automatic step(input bit v, input bit last, input int op, input int imm, input int cmd,
                       input int rd, input int rn, input int src, input bit st);
      bit was_close;
      was_close = m_close;
      in_valid  = v;
      in_last   = last;
      in_op     = op[1:0];
      in_imm    = imm[0];
      in_cmd    = cmd[4:0];
      in_rd     = rd[3:0];
      in_rn     = rn[3:0];
      in_src    = src[15:0];
      start     = st && (m_busy || m_close);
      base_addr = AW'($urandom);
      chk("in_ready", 64'(in_ready), 64'(m_ready));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("word_count", 64'(word_count), 64'(m_cnt));
      if (v && m_ready) begin
         if (ref_legal(op, cmd)) begin
            wq.push_back('{cyc + 1, m_ptr, ref_enc(op, imm, cmd, rd, rn, src)});
            m_ptr = (m_ptr + 1) % (1 << AW);
            m_cnt++;
         end else begin
            eq.push_back(cyc + 1);
         end
         if (last || m_cnt == MW) begin
            m_ready = 1'b0;
            m_busy  = 1'b0;
            m_close = 1'b1;
            dq.push_back(cyc + 2);
         end
      end
      if (was_close) m_close = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
   endtask

   task automatic open_session(input int b);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      start     = 1'b1;
      base_addr = AW'(b);
      chk("idle_in_ready", 64'(in_ready), 64'(0));
      @(negedge clk);
      start   = 1'b0;
      m_ptr   = b % (1 << AW);
      m_cnt   = 0;
      m_busy  = 1'b1;
      m_ready = 1'b1;
      m_close = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_imem_we"}, 64'(imem_we), 64'(0));
      chk({tag, "_imem_addr"}, 64'(imem_addr), 64'(0));
      chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(0));
      chk({tag, "_err_illegal"}, 64'(err_illegal), 64'(0));
      chk({tag, "_word_count"}, 64'(word_count), 64'(0));
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;  start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
      in_op = '0; in_imm = 1'b0; in_cmd = '0; in_rd = '0; in_rn = '0; in_src = '0;
      m_ptr = 0; m_cnt = 0; m_ready = 1'b0; m_busy = 1'b0; m_close = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // ADD register form, garbage in upper src bits must be masked
      open_session(8'h10);
      step(1'b1, 1'b1, 0, 0, 4, 2, 0, 16'hABC3, 1'b0);
      chk("t1_wdata", 64'(imem_wdata), 64'h0420_0003);
      chk("t1_addr", 64'(imem_addr), 64'h10);
      idle(3);
      chk("t1_word_count", 64'(word_count), 64'd1);

      // MEMORY STR with immediate
      open_session(8'h20);
      step(1'b1, 1'b1, 1, 1, 1, 4, 5, 16'hBEEF, 1'b0);
      chk("t2_wdata", 64'(imem_wdata), 64'h6145_BEEF);
      idle(3);

      // Back-to-back with an illegal third beat
      open_session(8'h10);
      step(1'b1, 1'b0, 0, 0, 1, 1, 1, 1, 1'b0);
      step(1'b1, 1'b0, 2, 1, 1, 2, 2, 16'h1234, 1'b1);
      step(1'b1, 1'b0, 3, 0, 0, 3, 3, 3, 1'b0);
      step(1'b1, 1'b1, 1, 0, 0, 4, 4, 4, 1'b0);
      idle(3);
      chk("t3_word_count", 64'(word_count), 64'd3);

      // MAX_WORDS cut-off without in_last
      open_session(8'h40);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 1, 12, i, i, 16'h5A00 + i, 1'b0);
      idle(3);
      chk("t4_word_count", 64'(word_count), 64'(MW));

      // Address wrap
      open_session(8'hFE);
      step(1'b1, 1'b0, 2, 0, 0, 1, 2, 3, 1'b0);
      step(1'b1, 1'b0, 2, 0, 1, 1, 2, 3, 1'b0);
      step(1'b1, 1'b1, 0, 0, 0, 1, 2, 3, 1'b0);
      chk("t5_wrap_addr", 64'(imem_addr), 64'h00);
      idle(3);

      // Illegal beats (PROCESSING above COS, MEMORY cmd[4:2]) with in_last still closes
      open_session(8'h80);
      step(1'b1, 1'b0, 0, 0, 13, 1, 1, 1, 1'b0);
      step(1'b1, 1'b0, 0, 0, 12, 1, 1, 1, 1'b0);
      step(1'b1, 1'b1, 1, 0, 4, 1, 1, 1, 1'b0);
      idle(3);
      chk("ill_last_word_count", 64'(word_count), 64'd1);

      // Reset the cycle after an accept
      open_session(8'h30);
      in_valid = 1'b1; in_last = 1'b0; in_op = 2'b00; in_imm = 1'b0; in_cmd = 5'd2;
      chk("t6_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      rst = 1'b1;
      in_valid = 1'b0;
      m_ptr = 0; m_cnt = 0; m_ready = 1'b0; m_busy = 1'b0; m_close = 1'b0;
      @(negedge clk);
      check_reset_outputs("t6_rst");
      @(negedge clk);
      check_reset_outputs("t6_rst_hold");
      rst = 1'b0;
      @(negedge clk);
      open_session(8'h31);
      step(1'b1, 1'b1, 0, 1, 7, 9, 8, 16'hC0DE, 1'b0);
      idle(3);

      // Randomized sessions with stray starts
      for (int s = 0; s < 60; s++) begin
         open_session(int'($urandom_range(0, 255)));
         n = 0;
         while (m_busy) begin
            bit v, l;
            int op, cmd;
            v   = ($urandom_range(0, 3) != 0);
            l   = ($urandom_range(0, 5) == 0) || (n >= 15);
            if (n >= 15) v = 1'b1;
            op  = int'($urandom_range(0, 3));
            cmd = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31))
                                              : int'($urandom_range(0, 1));
            step(v, l, op, int'($urandom_range(0, 1)), cmd, int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
                 ($urandom_range(0, 4) == 0));
            n++;
         end
         step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
         idle(int'($urandom_range(1, 2)));
      end

      idle(2);
      chk("writes_outstanding", 64'(wq.size()), 64'(0));
      chk("errs_outstanding", 64'(eq.size()), 64'(0));
      chk("dones_outstanding", 64'(dq.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
